branch_redirect_ctrl: RTL and testbench

//   Sequences the pipeline after the EX-stage branch resolver reports a branch outcome.
//   On a taken branch it issues one registered PC redirect to fetch, then squashes

---
 rtl/branch_redirect_ctrl_if.sv | 31 +++
 rtl/branch_redirect_ctrl.sv | 99 +++++++++
 tb/tb_branch_redirect_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/branch_redirect_ctrl_if.sv
// rtl/branch_redirect_ctrl_if.sv - EX branch outcome in, redirect/flush/statistics out
interface branch_redirect_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              ex_valid;
    logic              ex_is_branch;
    logic              ex_branch_taken;
    logic [ADDR_W-1:0] ex_target;
    logic              stall;
    logic              clear_stats;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush_if;
    logic              flush_id;
    logic              busy;
    logic [CNT_W-1:0]  branch_count;
    logic [CNT_W-1:0]  taken_count;

    modport master (
        output ex_valid, ex_is_branch, ex_branch_taken, ex_target, stall, clear_stats,
        input  redirect_valid, redirect_pc, flush_if, flush_id, busy,
               branch_count, taken_count
    );

    modport slave (
        input  ex_valid, ex_is_branch, ex_branch_taken, ex_target, stall, clear_stats,
        output redirect_valid, redirect_pc, flush_if, flush_id, busy,
               branch_count, taken_count
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - taken-branch PC redirect, IF/ID squash sequencing and branch statistics
module branch_redirect_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_redirect_ctrl_if.slave  bus
);
    localparam int SQ_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SQUASH   = 2'd2
    } state_t;

    state_t          state;
    logic [SQ_W-1:0] sq_cnt;
    logic            accept;

    // While busy, anything in EX is wrong-path and must not be accepted.
    assign accept = bus.ex_valid & bus.ex_is_branch & ~bus.stall & (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            sq_cnt             <= '0;
            bus.redirect_pc    <= '0;
            bus.redirect_valid <= 1'b0;
            bus.flush_if       <= 1'b0;
            bus.flush_id       <= 1'b0;
            bus.busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && bus.ex_branch_taken) begin
                        state              <= REDIRECT;
                        bus.redirect_pc    <= bus.ex_target;
                        sq_cnt             <= SQ_W'(FLUSH_CYCLES - 1);
                        bus.redirect_valid <= 1'b1;
                        bus.flush_if       <= 1'b1;
                        bus.flush_id       <= 1'b1;
                        bus.busy           <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (!bus.stall) begin
                        bus.redirect_valid <= 1'b0;
                        if (sq_cnt != '0) begin
                            state <= SQUASH;
                        end else begin
                            state        <= IDLE;
                            bus.flush_if <= 1'b0;
                            bus.flush_id <= 1'b0;
                            bus.busy     <= 1'b0;
                        end
                    end
                end
                SQUASH: begin
                    if (!bus.stall) begin
                        sq_cnt <= sq_cnt - 1'b1;
                        if (sq_cnt == SQ_W'(1)) begin
                            state        <= IDLE;
                            bus.flush_if <= 1'b0;
                            bus.flush_id <= 1'b0;
                            bus.busy     <= 1'b0;
                        end
                    end
                end
                default: begin
                    state              <= IDLE;
                    bus.redirect_valid <= 1'b0;
                    bus.flush_if       <= 1'b0;
                    bus.flush_id       <= 1'b0;
                    bus.busy           <= 1'b0;
                end
            endcase
        end
    end

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.branch_count <= '0;
            bus.taken_count  <= '0;
        end else if (bus.clear_stats) begin
            bus.branch_count <= '0;
            bus.taken_count  <= '0;
        end else begin
            if (accept && bus.branch_count != CNT_MAX)
                bus.branch_count <= bus.branch_count + 1'b1;
            if (accept && bus.ex_branch_taken && bus.taken_count != CNT_MAX)
                bus.taken_count <= bus.taken_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - directed scoreboard bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_redirect_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    branch_redirect_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        string       tag;
        logic [43:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;

    function automatic logic [43:0] pack(input logic rv, input logic [31:0] pc, input logic fi,
                                         input logic fd, input logic bz, input logic [3:0] bc,
                                         input logic [3:0] tc);
        return {rv, pc, fi, fd, bz, bc, tc};
    endfunction

    task automatic push_exp(input string tag, input logic rv, input logic [31:0] pc,
                            input logic fl, input logic bz, input logic [3:0] bc,
                            input logic [3:0] tc);
        exp_t e;
        e.tag = tag;
        e.v   = pack(rv, pc, fl, fl, bz, bc, tc);
        exp_q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t        e;
        logic [43:0] obs;
        obs = pack(bus.redirect_valid, bus.redirect_pc, bus.flush_if, bus.flush_id, bus.busy,
                   bus.branch_count, bus.taken_count);
        if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $error("FAIL scoreboard_empty observed=%h required=entry", obs);
        end else begin
            e = exp_q.pop_front();
            vectors++;
            assert (obs === e.v)
            else begin
                errors++;
                $error("FAIL %s observed=%h required=%h (rv,pc,fi,fd,busy,bc,tc)", e.tag, obs, e.v);
            end
        end
    endtask

    // Drive one cycle of EX inputs, queue the expected post-edge outputs, then compare.
    task automatic step(input string tag, input logic v, input logic br, input logic tk,
                        input logic [31:0] tgt, input logic st, input logic clr,
                        input logic e_rv, input logic [31:0] e_pc, input logic e_fl,
                        input logic e_bz, input logic [3:0] e_bc, input logic [3:0] e_tc);
        bus.ex_valid        = v;
        bus.ex_is_branch    = br;
        bus.ex_branch_taken = tk;
        bus.ex_target       = tgt;
        bus.stall           = st;
        bus.clear_stats     = clr;
        push_exp(tag, e_rv, e_pc, e_fl, e_bz, e_bc, e_tc);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    initial begin
        bus.ex_valid        = 1'b0;
        bus.ex_is_branch    = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.ex_target       = '0;
        bus.stall           = 1'b0;
        bus.clear_stats     = 1'b0;
        #3;
        push_exp("reset_state", 0, 32'h0, 0, 0, 4'd0, 4'd0);
        check_pop();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Taken branch, no stall
        step("tk_redirect", 1, 1, 1, 32'h40, 0, 0,  1, 32'h40, 1, 1, 4'd1, 4'd1);
        step("tk_squash",   0, 0, 0, 32'h0,  0, 0,  0, 32'h40, 1, 1, 4'd1, 4'd1);
        step("tk_idle",     0, 0, 0, 32'h0,  0, 0,  0, 32'h40, 0, 0, 4'd1, 4'd1);

        // Not-taken branch only counts
        step("nt_branch",   1, 1, 0, 32'h77, 0, 0,  0, 32'h40, 0, 0, 4'd2, 4'd1);
        step("nt_idle",     0, 0, 0, 32'h0,  0, 0,  0, 32'h40, 0, 0, 4'd2, 4'd1);
        // Stalled branch in IDLE is not accepted
        step("idle_stall",  1, 1, 1, 32'h99, 1, 0,  0, 32'h40, 0, 0, 4'd2, 4'd1);
        step("non_branch",  1, 0, 1, 32'h99, 0, 0,  0, 32'h40, 0, 0, 4'd2, 4'd1);

        // Stall during REDIRECT holds redirect for 4 cycles total
        step("st_redirect", 1, 1, 1, 32'h40, 0, 0,  1, 32'h40, 1, 1, 4'd3, 4'd2);
        for (int i = 0; i < 3; i++)
            step("st_hold", 1, 1, 1, 32'hBEEF, 1, 0, 1, 32'h40, 1, 1, 4'd3, 4'd2);
        step("st_squash",   0, 0, 0, 32'h0,  0, 0,  0, 32'h40, 1, 1, 4'd3, 4'd2);
        step("st_idle",     0, 0, 0, 32'h0,  0, 0,  0, 32'h40, 0, 0, 4'd3, 4'd2);

        // Wrong-path branches while busy and on the busy->IDLE edge
        step("wp_redirect", 1, 1, 1, 32'h1234_5678, 0, 0, 1, 32'h1234_5678, 1, 1, 4'd4, 4'd3);
        step("wp_in_redir", 1, 1, 1, 32'h9999,      0, 0, 0, 32'h1234_5678, 1, 1, 4'd4, 4'd3);
        step("wp_in_squash",1, 1, 1, 32'hAAAA,      0, 0, 0, 32'h1234_5678, 0, 0, 4'd4, 4'd3);
        step("wp_idle",     0, 0, 0, 32'h0,         0, 0, 0, 32'h1234_5678, 0, 0, 4'd4, 4'd3);

        // Stall during SQUASH holds without decrementing
        step("sq_redirect", 1, 1, 1, 32'h100, 0, 0, 1, 32'h100, 1, 1, 4'd5, 4'd4);
        step("sq_enter",    0, 0, 0, 32'h0,   0, 0, 0, 32'h100, 1, 1, 4'd5, 4'd4);
        step("sq_stall",    0, 0, 0, 32'h0,   1, 0, 0, 32'h100, 1, 1, 4'd5, 4'd4);
        step("sq_stall2",   0, 0, 0, 32'h0,   1, 0, 0, 32'h100, 1, 1, 4'd5, 4'd4);
        step("sq_leave",    0, 0, 0, 32'h0,   0, 0, 0, 32'h100, 0, 0, 4'd5, 4'd4);

        // Asynchronous reset in the middle of SQUASH
        step("rs_redirect", 1, 1, 1, 32'h200, 0, 0, 1, 32'h200, 1, 1, 4'd6, 4'd5);
        step("rs_squash",   0, 0, 0, 32'h0,   0, 0, 0, 32'h200, 1, 1, 4'd6, 4'd5);
        #2 rst_n = 1'b0;
        #1;
        push_exp("rs_async", 0, 32'h0, 0, 0, 4'd0, 4'd0);
        check_pop();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("rs_after1",   0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 4'd0, 4'd0);
        step("rs_after2",   0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 4'd0, 4'd0);

        // Saturation at 2^CNT_W-1 and clear priority
        for (int i = 1; i <= 15; i++)
            step("sat_fill", 1, 1, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 4'(i), 4'd0);
        step("sat_taken",   1, 1, 1, 32'h300, 0, 0, 1, 32'h300, 1, 1, 4'd15, 4'd1);
        step("sat_sq",      0, 0, 0, 32'h0,   0, 0, 0, 32'h300, 1, 1, 4'd15, 4'd1);
        step("sat_idle",    0, 0, 0, 32'h0,   0, 0, 0, 32'h300, 0, 0, 4'd15, 4'd1);
        step("sat_hold",    1, 1, 0, 32'h0,   0, 0, 0, 32'h300, 0, 0, 4'd15, 4'd1);
        step("clr_accept",  1, 1, 1, 32'h400, 0, 1, 1, 32'h400, 1, 1, 4'd0, 4'd0);
        step("clr_sq",      0, 0, 0, 32'h0,   0, 0, 0, 32'h400, 1, 1, 4'd0, 4'd0);
        step("clr_idle",    0, 0, 0, 32'h0,   0, 0, 0, 32'h400, 0, 0, 4'd0, 4'd0);

        vectors++;
        assert (exp_q.size() == 0)
        else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d required=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
